// File: rtl/flappy_pkg.sv
// Shared game constants: FSM state encoding, spawn height table, LFSR seed/taps
// and screen geometry used by the pipe scheduler and the pipe datapath blocks.
package flappy_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LOST = 2'd2
  } state_t;

  localparam int          SCREEN_W         = 1024;
  localparam logic [9:0]  PIPE_PARK_X      = 10'd1023;

  // Fibonacci taps 16,14,13,11 expressed as a mask over bits [15:0]
  localparam logic [15:0] LFSR_SEED        = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS        = 16'hB400;
  localparam logic [9:0]  LFSR_HEIGHT_BASE = 10'd100;

  function automatic logic [9:0] height_lut(input logic [2:0] idx);
    logic [9:0] h;
    case (idx)
      3'd0:    h = 10'd300;
      3'd1:    h = 10'd100;
      3'd2:    h = 10'd210;
      3'd3:    h = 10'd250;
      3'd4:    h = 10'd170;
      3'd5:    h = 10'd190;
      3'd6:    h = 10'd230;
      default: h = 10'd200;
    endcase
    return h;
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running divider that emits a one-cycle Tick every DIV enabled cycles;
// the count is held at zero whenever En is low.
module tick_divider
  import flappy_pkg::*;
#(
  parameter int DIV = 500000
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic En,
  output logic Tick
);

  localparam int               CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_cnt <= '0;
    end else if (!En || r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign Tick = En && (r_cnt == LAST);

endmodule

// File: rtl/pipe_scheduler.sv
// Game controller: run/lost FSM, shared pipe MoveTick, round-robin pipe spawning and scoring.
// Define LFSR_HEIGHT_EN to draw spawn heights from a 16-bit LFSR instead of the constant table.
module pipe_scheduler
  import flappy_pkg::*;
#(
  parameter int NUM_PIPES = 3,
  parameter int TICK_DIV  = 500000,
  parameter int SPAWN_GAP = 350,
  parameter int BIRD_X    = 200,
  parameter int SCORE_W   = 8
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic                   Start,
  input  logic                   Collide,
  input  logic [NUM_PIPES-1:0]   PipeActive,
  input  logic [NUM_PIPES*10-1:0] PipeX,
  output logic                   MoveTick,
  output logic [NUM_PIPES-1:0]   Spawn,
  output logic [9:0]             SpawnHeight,
  output logic                   ClearPipes,
  output logic                   Running,
  output logic                   GameOver,
  output logic [SCORE_W-1:0]     Score
);

  localparam int               IDX_W    = $clog2(NUM_PIPES);
  localparam int               GAP_W    = (SPAWN_GAP > 1) ? $clog2(SPAWN_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(SPAWN_GAP - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_PIPES - 1);

  state_t               r_state, w_state_next;
  logic                 r_start_q;
  logic [GAP_W-1:0]     r_gap_cnt;
  logic                 r_due;
  logic                 r_check;
  logic [IDX_W-1:0]     r_idx;
  logic [SCORE_W-1:0]   r_score;
  logic                 w_start_edge;
  logic                 w_run;
  logic                 w_live;
  logic                 w_fire;
  logic                 w_score_hit;
  logic [NUM_PIPES-1:0] w_hit;
  logic [9:0]           w_height;

  assign w_start_edge = Start & ~r_start_q;
  assign w_run        = (r_state == RUN);
  assign w_live       = w_run & ~Collide;

  tick_divider #(.DIV(TICK_DIV)) u_move_tick (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .En      (w_run),
    .Tick    (MoveTick)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    ClearPipes   = 1'b0;
    Running      = 1'b0;
    GameOver     = 1'b0;
    case (r_state)
      IDLE: begin
        ClearPipes = 1'b1;
        if (w_start_edge) w_state_next = RUN;
      end
      RUN: begin
        Running = 1'b1;
        if (Collide) w_state_next = LOST;
      end
      LOST: begin
        GameOver = 1'b1;
        if (w_start_edge) w_state_next = IDLE;
      end
      default: begin
        ClearPipes   = 1'b1;
        w_state_next = IDLE;
      end
    endcase
  end

  // r_check marks the cycle after a MoveTick, when pipe positions are fresh
  genvar gi;
  generate
    for (gi = 0; gi < NUM_PIPES; gi++) begin : g_hit
      assign w_hit[gi] = PipeActive[gi] && (PipeX[10*gi +: 10] == 10'(BIRD_X));
    end
  endgenerate

  assign w_score_hit = r_check & w_live & (|w_hit);
  assign w_fire      = r_check & r_due & w_live & ~PipeActive[r_idx];
  assign Spawn       = w_fire ? (NUM_PIPES'(1) << r_idx) : '0;
  assign SpawnHeight = w_fire ? w_height : '0;
  assign Score       = r_score;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_start_q <= 1'b0;
      r_gap_cnt <= '0;
      r_due     <= 1'b0;
      r_check   <= 1'b0;
      r_idx     <= '0;
      r_score   <= '0;
    end else begin
      r_start_q <= Start;
      r_check   <= MoveTick;
      r_due     <= MoveTick & w_live & (r_gap_cnt == GAP_LAST);
      if (r_state == IDLE && w_start_edge) begin
        r_gap_cnt <= GAP_LAST;
        r_score   <= '0;
      end else begin
        if (w_fire) r_gap_cnt <= '0;
        else if (MoveTick && w_live && r_gap_cnt != GAP_LAST) r_gap_cnt <= r_gap_cnt + 1'b1;
        if (w_score_hit && r_score != '1) r_score <= r_score + 1'b1;
      end
      if (w_fire) r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
    end
  end

`ifdef LFSR_HEIGHT_EN
  logic [15:0] r_lfsr;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) r_lfsr <= LFSR_SEED;
    else          r_lfsr <= {r_lfsr[14:0], ^(r_lfsr & LFSR_TAPS)};
  end

  assign w_height = LFSR_HEIGHT_BASE + {2'b00, r_lfsr[7:0]};
`else
  logic [2:0] r_hidx;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)    r_hidx <= '0;
    else if (w_fire) r_hidx <= r_hidx + 1'b1;
  end

  assign w_height = height_lut(r_hidx);
`endif

endmodule

// File: tb/tb_pipe_scheduler.sv
// Self-checking bench for pipe_scheduler: directed vector tables, hand-written corner
// sequences and random stimulus, all checked against a behavioural game model.
module tb_pipe_scheduler;

  localparam int NP  = 3;
  localparam int TD  = 4;
  localparam int GAP = 3;
  localparam int BX  = 200;
  localparam int SW  = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             collide = 1'b0;
  logic [NP-1:0]    active = '0;
  logic [NP*10-1:0] pipex = '0;
  logic             move_tick;
  logic [NP-1:0]    spawn;
  logic [9:0]       spawn_h;
  logic             clear_pipes, running, game_over;
  logic [SW-1:0]    score;

  always #5 clk = ~clk;

  pipe_scheduler #(
    .NUM_PIPES(NP), .TICK_DIV(TD), .SPAWN_GAP(GAP), .BIRD_X(BX), .SCORE_W(SW)
  ) dut (
    .Clk(clk), .Reset_n(rst_n), .Start(start), .Collide(collide),
    .PipeActive(active), .PipeX(pipex), .MoveTick(move_tick), .Spawn(spawn),
    .SpawnHeight(spawn_h), .ClearPipes(clear_pipes), .Running(running),
    .GameOver(game_over), .Score(score)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int heights[8] = '{300, 100, 210, 250, 170, 190, 230, 200};

  // Behavioural model: 0=idle 1=run 2=lost, counts kept as plain integers
  int m_state, m_run_cyc, m_since, m_idx, m_hcnt, m_score;
  bit m_due, m_check, m_start_q;
`ifdef LFSR_HEIGHT_EN
  logic [15:0] m_lfsr;
`endif

  bit s_tick, s_run, s_clear, s_over;
  int s_spawn, s_height, s_score, e_height;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int height_ref();
`ifdef LFSR_HEIGHT_EN
    return 100 + int'(m_lfsr[7:0]);
`else
    return heights[m_hcnt % 8];
`endif
  endfunction

  function automatic bit model_due_now();
    return (m_state == 1) && (m_run_cyc % TD == TD - 1) && (m_since + 1 >= GAP);
  endfunction

  task automatic model_reset();
    m_state = 0; m_run_cyc = 0; m_since = 0; m_idx = 0; m_hcnt = 0; m_score = 0;
    m_due = 0; m_check = 0; m_start_q = 0;
`ifdef LFSR_HEIGHT_EN
    m_lfsr = 16'hACE1;
`endif
  endtask

  // Called right after a falling edge with inputs driven; returns at the next falling edge.
  task automatic cycle();
    bit edge_s, run, live, tick, fire, hit;
    int exp_sp, exp_h;
    #1;
    edge_s = start && !m_start_q;
    run    = (m_state == 1);
    live   = run && !collide;
    tick   = run && (m_run_cyc % TD == TD - 1);
    fire   = live && m_due && !active[m_idx];
    exp_sp = fire ? (1 << m_idx) : 0;
    exp_h  = fire ? height_ref() : 0;
    hit    = 0;
    for (int i = 0; i < NP; i++)
      if (active[i] && pipex[10*i +: 10] == 10'(BX)) hit = 1;
    hit = hit && live && m_check;

    s_tick = move_tick; s_run = running; s_clear = clear_pipes; s_over = game_over;
    s_spawn = int'(spawn); s_height = int'(spawn_h); s_score = int'(score); e_height = exp_h;
    chk("flags", int'({move_tick, clear_pipes, running, game_over}),
        int'({tick, m_state == 0, run, m_state == 2}));
    chk("spawn", s_spawn, exp_sp);
    chk("height", s_height, exp_h);
    chk("score", s_score, m_score);
    if (spawn != '0)
      $display("spawn #%0d pipe=%b height=%0d score=%0d t=%0t", m_hcnt, spawn, spawn_h, score, $time);

    if (fire) begin
      m_idx = (m_idx + 1) % NP; m_hcnt++; m_since = 0;
    end
    m_due = tick && live && (m_since + 1 >= GAP);
    if (tick && live) m_since++;
    m_check = tick;
    if (hit && m_score < (1 << SW) - 1) m_score++;
    if (run) m_run_cyc++;
    if (m_state == 0 && edge_s) begin
      m_state = 1; m_score = 0; m_since = GAP - 1; m_run_cyc = 0;
    end else if (m_state == 1 && collide) begin
      m_state = 2;
    end else if (m_state == 2 && edge_s) begin
      m_state = 0;
    end
    m_start_q = start;
`ifdef LFSR_HEIGHT_EN
    m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
`endif
    @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_tick"}, int'(move_tick), 0);
    chk({tag, "_spawn"}, int'(spawn), 0);
    chk({tag, "_height"}, int'(spawn_h), 0);
    chk({tag, "_clear"}, int'(clear_pipes), 1);
    chk({tag, "_running"}, int'(running), 0);
    chk({tag, "_gameover"}, int'(game_over), 0);
    chk({tag, "_score"}, int'(score), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; collide = 1'b0; active = '0; pipex = '0;
    repeat (2) @(negedge clk);
    #1 check_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic wait_spawn(input int limit, output int ticks, output bit found);
    ticks = 0; found = 0;
    for (int c = 0; c < limit && !found; c++) begin
      cycle();
      if (s_tick) ticks++;
      if (s_spawn != 0) found = 1;
    end
  endtask

  typedef struct {
    bit         start;
    bit         tick;
    bit         run;
    logic [2:0] spawn;
    int         height;
  } vec_t;

  typedef struct {
    logic [2:0] spawn;
    int         height;
  } sp_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t t1[7];
    sp_t  t2[3];
    int   ticks, n_sp;
    bit   found;

    t1 = '{'{0, 0, 0, 3'b000, 0}, '{1, 0, 0, 3'b000, 0}, '{1, 0, 1, 3'b000, 0},
           '{0, 0, 1, 3'b000, 0}, '{0, 0, 1, 3'b000, 0}, '{0, 1, 1, 3'b000, 0},
           '{0, 0, 1, 3'b001, 300}};
    t2 = '{'{3'b010, 100}, '{3'b100, 210}, '{3'b001, 250}};

    do_reset();

    // Start edge, first MoveTick and first spawn, cycle by cycle
    for (int i = 0; i < 7; i++) begin
      start = t1[i].start; collide = 1'b0; active = '0;
      cycle();
      $display("vec %0d start=%0d tick=%0d run=%0d spawn=%b height=%0d", i, t1[i].start, s_tick, s_run, s_spawn[2:0], s_height);
      chk("t1_tick", int'(s_tick), int'(t1[i].tick));
      chk("t1_run", int'(s_run), int'(t1[i].run));
      chk("t1_spawn", s_spawn, int'(t1[i].spawn));
`ifndef LFSR_HEIGHT_EN
      chk("t1_height", s_height, t1[i].height);
`endif
    end

    // Round-robin spawns every SPAWN_GAP MoveTicks
    for (int i = 0; i < 3; i++) begin
      active = '0;
      wait_spawn(60, ticks, found);
      chk("t2_found", int'(found), 1);
      chk("t2_spawn", s_spawn, int'(t2[i].spawn));
      chk("t2_spacing", ticks, GAP);
`ifndef LFSR_HEIGHT_EN
      chk("t2_height", s_height, t2[i].height);
`endif
    end

    // Pipe 1 busy when due: defer without skipping it
    ticks = 0; n_sp = 0;
    for (int c = 0; c < 80 && ticks < 5; c++) begin
      active = 3'b010;
      cycle();
      if (s_tick) ticks++;
      if (s_spawn != 0) n_sp++;
    end
    chk("defer_ticks", ticks, 5);
    cycle();
    if (s_spawn != 0) n_sp++;
    chk("defer_nospawn", n_sp, 0);
    active = '0;
    wait_spawn(40, ticks, found);
    chk("defer_found", int'(found), 1);
    chk("defer_spawn", s_spawn, 3'b010);
    chk("defer_ticks_after", ticks, 1);

    // Scoring: pipe 0 parked at BIRD_X
    active = 3'b001; pipex = '0; pipex[9:0] = 10'(BX);
    ticks = 0;
    for (int c = 0; c < 40 && ticks < 3; c++) begin
      cycle();
      if (s_tick) ticks++;
    end
    cycle(); cycle();
    chk("score_three", s_score, 3);
    ticks = 0;
    for (int c = 0; c < 1300 && ticks < 260; c++) begin
      cycle();
      if (s_tick) ticks++;
    end
    cycle(); cycle();
    chk("score_saturate", s_score, 255);

    // Collide in the same cycle a spawn is due
    active = '0; pipex = '0;
    found = 0;
    for (int c = 0; c < 60 && !found; c++) begin
      if (model_due_now()) begin collide = 1'b1; found = 1; end
      cycle();
      collide = 1'b0;
    end
    chk("collide_found", int'(found), 1);
    ticks = 0; n_sp = 0;
    for (int c = 0; c < 12; c++) begin
      cycle();
      if (s_tick) ticks++;
      if (s_spawn != 0) n_sp++;
    end
    chk("lost_ticks", ticks, 0);
    chk("lost_spawns", n_sp, 0);
    chk("lost_gameover", int'(s_over), 1);
    start = 1'b1; cycle(); start = 1'b0; cycle();
    chk("idle_clear", int'(s_clear), 1);
    chk("idle_score_held", s_score, 255);
    start = 1'b1; cycle(); start = 1'b0; cycle();
    chk("restart_run", int'(s_run), 1);
    chk("restart_score", s_score, 0);

    // Random play against the model
    for (int c = 0; c < 3000; c++) begin
      start   = ($urandom_range(99) < 4);
      collide = ($urandom_range(199) < 2);
      if ($urandom_range(7) == 0) active = NP'($urandom);
      for (int i = 0; i < NP; i++)
        pipex[10*i +: 10] = ($urandom_range(1) == 1) ? 10'(BX) : 10'($urandom);
      cycle();
    end

    // Asynchronous reset in the middle of a run
    do_reset();
    start = 1'b1; cycle(); start = 1'b0;
    repeat (8) cycle();
    chk("pre_async_run", int'(s_run), 1);
    #2 rst_n = 1'b0;
    #1 check_reset_values("async");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    start = 1'b1; cycle(); start = 1'b0;
    wait_spawn(40, ticks, found);
    chk("first_spawn_found", int'(found), 1);
    chk("first_spawn_height", s_height, e_height);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
